// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer and uart_tx: data/valid in, ready back.
// Ready means the one-entry holding buffer is empty; valid is ignored while ready is low.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// Double-buffered UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stops.
// A buffered byte starts on the next T_byte (back-to-back with no idle gap); ready drops while the buffer is full.
module uart_tx #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     T_byte,
   uart_tx_if.slave up,
   output logic     Serial_out,
   output logic     tx_busy,
   output logic     tx_done
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = (STOP_BITS == 2);
   localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
   localparam logic       ODD       = (PARITY_ODD != 0);

   state_t     state_q, state_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       stop_cnt_q, stop_cnt_d;
   logic       par_q, par_d;
   logic       ser_q, ser_d;
   logic       done_q, done_d;
   logic       accept;
   logic       load;

   assign accept      = up.tx_valid && !hold_full_q;
   assign up.tx_ready = !hold_full_q;
   assign Serial_out  = ser_q;
   assign tx_busy     = (state_q != IDLE);
   assign tx_done     = done_q;

   always_comb begin
      state_d     = state_q;
      hold_data_d = hold_data_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      par_d       = par_q;
      ser_d       = ser_q;
      done_d      = 1'b0;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            ser_d = 1'b1;
            if (T_byte && hold_full_q) load = 1'b1;
         end
         START: if (T_byte) begin
            ser_d     = shift_q[0];
            bit_cnt_d = '0;
            state_d   = DATA;
         end
         DATA: if (T_byte) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q < LAST_BIT) begin
               shift_d = shift_q >> 1;
               ser_d   = shift_q[1];
            end else if (PARITY_EN != 0) begin
               ser_d   = par_q;
               state_d = PARITY;
            end else begin
               ser_d      = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = STOP;
            end
         end
         PARITY: if (T_byte) begin
            ser_d      = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
         end
         STOP: if (T_byte) begin
            if (stop_cnt_q == LAST_STOP) begin
               done_d = 1'b1;
               if (hold_full_q) begin
                  load = 1'b1;
               end else begin
                  ser_d   = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            ser_d   = 1'b1;
         end
      endcase

      // Parity is latched with the byte so later buffer writes cannot disturb it.
      if (load) begin
         shift_d     = hold_data_q;
         par_d       = ^(hold_data_q & DATA_MASK) ^ ODD;
         ser_d       = 1'b0;
         state_d     = START;
         hold_full_d = 1'b0;
      end
      if (accept) begin
         hold_data_d = up.tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         hold_data_q <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= 1'b0;
         par_q       <= 1'b0;
         ser_q       <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_data_q <= hold_data_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         par_q       <= par_d;
         ser_q       <= ser_d;
         done_q      <= done_d;
      end
   end
endmodule
